// File: rtl/dma_priority_arbiter.sv
// Priority and hold-request stage of an 8237-style DMA controller: qualifies
// requests, raises HRQ, picks the winning channel on HLDA and holds it until service ends.
module dma_priority_arbiter #(
   parameter int CHANNELS = 4,
   parameter int CHW      = 2
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [CHANNELS-1:0] DREQ,
   input  logic [CHANNELS-1:0] SW_REQ,
   input  logic [CHANNELS-1:0] MASK,
   input  logic                HLDA,
   input  logic                CTRL_DISABLE,
   input  logic                ROTATE,
   input  logic                DREQ_LOW,
   input  logic                DACK_HIGH,
   input  logic                SVC_DONE,
   output logic                HRQ,
   output logic [CHANNELS-1:0] DACK,
   output logic                GRANT_VALID,
   output logic [CHW-1:0]      ACTIVE_CH
);

   typedef enum logic [1:0] {IDLE, REQ, GRANT} state_t;

   state_t              state, state_nxt;
   logic [CHANNELS-1:0] req;
   logic [CHANNELS-1:0] grant_q, grant_nxt;
   logic [CHW-1:0]      active_q, active_nxt;
   logic [CHW-1:0]      ptr_q, ptr_nxt;
   logic [CHW-1:0]      base, idx, winner;
   logic                any_req, found;

   // SW_REQ bypasses MASK, hardware DREQ does not.
   always_comb begin
      req     = ((DREQ ^ {CHANNELS{DREQ_LOW}}) & ~MASK) | SW_REQ;
      any_req = |req;
   end

   // Scan from the rotate pointer (or ch0 in fixed mode), wrapping modulo CHANNELS.
   always_comb begin
      base   = ROTATE ? ptr_q : '0;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         idx = CHW'((32'(base) + k) % CHANNELS);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         grant_q  <= '0;
         active_q <= '0;
         ptr_q    <= '0;
      end else begin
         state    <= state_nxt;
         grant_q  <= grant_nxt;
         active_q <= active_nxt;
         ptr_q    <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant_q;
      active_nxt = active_q;
      ptr_nxt    = ptr_q;
      case (state)
         IDLE: begin
            // A stale HLDA from the previous service blocks a new hold request.
            if (any_req && !CTRL_DISABLE && !HLDA) state_nxt = REQ;
         end
         REQ: begin
            if (!any_req) begin
               state_nxt = IDLE;
            end else if (HLDA) begin
               state_nxt         = GRANT;
               grant_nxt         = '0;
               grant_nxt[winner] = 1'b1;
               active_nxt        = winner;
            end
         end
         GRANT: begin
            // CPU revoking HLDA ends the grant exactly like SVC_DONE.
            if (SVC_DONE || !HLDA) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               if (ROTATE)
                  ptr_nxt = (active_q == CHW'(CHANNELS - 1)) ? '0 : active_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      HRQ         = (state != IDLE);
      GRANT_VALID = (state == GRANT);
      ACTIVE_CH   = active_q;
      DACK        = grant_q ^ {CHANNELS{~DACK_HIGH}};
   end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized and directed bench for dma_priority_arbiter; expected grants are
// queued by the stimulus and matched by a monitor when GRANT_VALID rises.
module tb_dma_priority_arbiter;

   localparam int N = 4;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [3:0] DREQ, SW_REQ, MASK;
   logic       HLDA, CTRL_DISABLE, ROTATE, DREQ_LOW, DACK_HIGH, SVC_DONE;
   logic       HRQ, GRANT_VALID;
   logic [3:0] DACK;
   logic [1:0] ACTIVE_CH;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         ch;
      logic [3:0] dack;
   } exp_t;

   exp_t       sb[$];
   exp_t       popped;
   int         model_ptr = 0;
   bit         mon_prev_gv = 1'b0;
   int         locked_ch = 0;
   logic [3:0] locked_dack = '0;

   dma_priority_arbiter #(.CHANNELS(4), .CHW(2)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .SW_REQ(SW_REQ), .MASK(MASK),
      .HLDA(HLDA), .CTRL_DISABLE(CTRL_DISABLE), .ROTATE(ROTATE), .DREQ_LOW(DREQ_LOW),
      .DACK_HIGH(DACK_HIGH), .SVC_DONE(SVC_DONE), .HRQ(HRQ), .DACK(DACK),
      .GRANT_VALID(GRANT_VALID), .ACTIVE_CH(ACTIVE_CH)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int model_winner(input logic [3:0] dreq, input logic [3:0] mask,
                                       input logic [3:0] sw, input bit dlow, input bit rot,
                                       input int ptr);
      for (int k = 0; k < N; k++) begin
         int c  = rot ? (ptr + k) % N : k;
         bit hw = dlow ? (dreq[c] == 1'b0) : (dreq[c] == 1'b1);
         if ((hw && !mask[c]) || sw[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] dack_of(input int ch, input bit dh);
      logic [3:0] oh = 4'b0001 << ch;
      return dh ? oh : ~oh;
   endfunction

   function automatic logic [3:0] dreq_idle(input bit dlow);
      return dlow ? 4'b1111 : 4'b0000;
   endfunction

   always @(negedge CLK) begin
      if (RESET_N) begin
         check("dack_onehot", 32'($countones(DACK ^ {4{~DACK_HIGH}}) <= 1), 1);
         if (!HRQ) check("hrq_low_gv", GRANT_VALID, 0);
         if (GRANT_VALID && !mon_prev_gv) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant: actual=ch%0d required=no grant", ACTIVE_CH);
            end else begin
               popped = sb.pop_front();
               check("grant_ch", ACTIVE_CH, popped.ch);
               check("grant_dack", DACK, popped.dack);
               locked_ch   = popped.ch;
               locked_dack = popped.dack;
            end
         end else if (GRANT_VALID) begin
            check("locked_ch", ACTIVE_CH, locked_ch);
            check("locked_dack", DACK, locked_dack);
         end
      end
      mon_prev_gv = GRANT_VALID;
   end

   // Entered and left in IDLE with HLDA=0; exp_ch<0 means the model picks the winner.
   task automatic do_txn(input logic [3:0] dreq, input logic [3:0] mask, input logic [3:0] sw,
                         input bit rot, input bit dlow, input bit dhigh, input int exp_ch,
                         input bit by_svc, input int wait_hlda, input int hold,
                         input bit scramble, input string tag);
      int w;
      ROTATE = rot; DREQ_LOW = dlow; DACK_HIGH = dhigh;
      MASK = mask; SW_REQ = sw; DREQ = dreq; CTRL_DISABLE = 1'b0;
      tick();
      check({tag, "_hrq_rise"}, HRQ, 1);
      check({tag, "_gv_req"}, GRANT_VALID, 0);
      repeat (wait_hlda) begin
         if (scramble) CTRL_DISABLE = 1'($urandom);
         tick();
      end
      w = (exp_ch >= 0) ? exp_ch : model_winner(dreq, mask, sw, dlow, rot, model_ptr);
      sb.push_back('{w, dack_of(w, dhigh)});
      HLDA = 1'b1;
      CTRL_DISABLE = 1'b0;
      tick();
      repeat (hold) begin
         if (scramble) begin
            DREQ = 4'($urandom); MASK = 4'($urandom); SW_REQ = 4'($urandom);
         end
         tick();
      end
      if (by_svc) begin
         SVC_DONE = 1'b1;
      end else begin
         HLDA = 1'b0; DREQ = dreq_idle(dlow); MASK = '0; SW_REQ = '0;
      end
      tick();
      SVC_DONE = 1'b0;
      check({tag, "_end_hrq"}, HRQ, 0);
      check({tag, "_end_gv"}, GRANT_VALID, 0);
      check({tag, "_end_dack"}, DACK, dhigh ? 4'b0000 : 4'b1111);
      check({tag, "_end_ch_hold"}, ACTIVE_CH, w);
      if (rot) model_ptr = (w + 1) % N;
      if (by_svc) begin
         tick();
         check({tag, "_stale_hlda"}, HRQ, 0);
         HLDA = 1'b0; DREQ = dreq_idle(dlow); MASK = '0; SW_REQ = '0;
      end
      tick();
      check({tag, "_idle_hrq"}, HRQ, 0);
   endtask

   initial begin
      logic [3:0] rd, rm, rs;
      bit         rrot, rdl, rdh;
      int         tries;

      RESET_N = 1'b0;
      DREQ = '0; SW_REQ = '0; MASK = '0; HLDA = 1'b0; CTRL_DISABLE = 1'b0;
      ROTATE = 1'b0; DREQ_LOW = 1'b0; DACK_HIGH = 1'b0; SVC_DONE = 1'b0;
      tick();
      tick();
      check("rst_hrq", HRQ, 0);
      check("rst_gv", GRANT_VALID, 0);
      check("rst_dack", DACK, 4'b1111);
      check("rst_ch", ACTIVE_CH, 0);
      RESET_N = 1'b1;

      // Basic flow, then fixed priority twice with the serviced channel still requesting.
      do_txn(4'b0010, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 2, 4, 0, "t1");
      do_txn(4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0, 1, 0, "t2a");
      do_txn(4'b1010, 4'b0000, 4'b0000, 0, 0, 0, 1, 1, 0, 1, 0, "t2b");

      // Rotating priority with all channels requesting.
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 0, 1, 0, "t3_0");
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 1, 1, 0, 1, 0, "t3_1");
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 2, 1, 0, 1, 0, "t3_2");
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 3, 1, 0, 1, 0, "t3_3");
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 0, 1, 0, 1, 0, "t3_4");

      // Masked DREQ is ignored, SW_REQ overrides the mask.
      ROTATE = 1'b0; MASK = 4'b0001; DREQ = 4'b0001; SW_REQ = '0;
      repeat (3) begin
         tick();
         check("t4_masked_hrq", HRQ, 0);
      end
      do_txn(4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 1, 0, 1, 0, "t4");

      // Pointer retained across fixed mode, then HLDA revoke on ch2 advances it to 3.
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 1, 1, 0, 1, 0, "rot_resume");
      do_txn(4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 2, 0, 0, 2, 0, "t5");
      do_txn(4'b1111, 4'b0000, 4'b0000, 1, 0, 0, 3, 1, 0, 1, 0, "t5_ptr");

      // Stale HLDA in IDLE blocks HRQ; request withdrawn before HLDA returns to IDLE.
      ROTATE = 1'b0; HLDA = 1'b1; DREQ = 4'b0001;
      repeat (2) begin
         tick();
         check("stale_hlda_hrq", HRQ, 0);
      end
      HLDA = 1'b0;
      tick();
      check("stale_release_hrq", HRQ, 1);
      DREQ = 4'b0000;
      tick();
      check("req_drop_hrq", HRQ, 0);

      // CTRL_DISABLE blocks new service; SVC_DONE in IDLE is ignored.
      CTRL_DISABLE = 1'b1; DREQ = 4'b0100;
      repeat (2) begin
         tick();
         check("disable_hrq", HRQ, 0);
      end
      SVC_DONE = 1'b1;
      tick();
      SVC_DONE = 1'b0;
      check("svc_idle_hrq", HRQ, 0);
      CTRL_DISABLE = 1'b0; DREQ = 4'b0000;
      tick();

      // Active-low DREQ, active-high DACK, async reset mid-grant.
      DREQ_LOW = 1'b1; DACK_HIGH = 1'b1; DREQ = 4'b1011;
      tick();
      check("t6_hrq", HRQ, 1);
      sb.push_back('{2, 4'b0100});
      HLDA = 1'b1;
      tick();
      @(negedge CLK);
      #1;
      RESET_N = 1'b0;
      #1;
      check("t6_rst_dack", DACK, 4'b0000);
      check("t6_rst_hrq", HRQ, 0);
      check("t6_rst_gv", GRANT_VALID, 0);
      check("t6_rst_ch", ACTIVE_CH, 0);
      HLDA = 1'b0; DREQ = 4'b1111;
      tick();
      RESET_N = 1'b1;
      model_ptr = 0;
      tick();
      check("t6_post_hrq", HRQ, 0);

      for (int t = 0; t < 40; t++) begin
         rrot = 1'($urandom); rdl = 1'($urandom); rdh = 1'($urandom);
         rd = 4'($urandom); rm = 4'($urandom); rs = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
         tries = 0;
         while (model_winner(rd, rm, rs, rdl, rrot, model_ptr) < 0 && tries < 50) begin
            rd = 4'($urandom); rm = 4'($urandom);
            tries++;
         end
         if (model_winner(rd, rm, rs, rdl, rrot, model_ptr) < 0) rs = 4'b1000;
         do_txn(rd, rm, rs, rrot, rdl, rdh, -1, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(1, 4), 1, "rnd");
      end

      repeat (3) tick();
      check("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
